// File: rtl/sine_rom_arbiter.sv
// Round-robin arbiter that shares a dual-port synchronous sine ROM between NUM_REQ requesters.
// Grants up to two reads per cycle and routes the ROM data back through registered responses.
module sine_rom_arbiter #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int NUM_REQ       = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]  req_addr,
    output logic [NUM_REQ-1:0]                gnt,
    output logic [NUM_REQ-1:0]                rsp_valid,
    output logic [NUM_REQ*DATA_WIDTH-1:0]     rsp_data,
    output logic [ADDRESS_WIDTH-1:0]          rom_addr1,
    output logic [ADDRESS_WIDTH-1:0]          rom_addr2,
    input  logic [DATA_WIDTH-1:0]             rom_dout1,
    input  logic [DATA_WIDTH-1:0]             rom_dout2
);

    localparam int ID_W = $clog2(NUM_REQ);

    // Requester index reached k steps after base, wrapping modulo NUM_REQ.
    function automatic logic [ID_W-1:0] idx_at(input logic [ID_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) s -= NUM_REQ;
        return ID_W'(s);
    endfunction

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return (int'(id) == NUM_REQ - 1) ? '0 : id + 1'b1;
    endfunction

    logic [ADDRESS_WIDTH-1:0] addr_arr [NUM_REQ];

    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic                  tag1_valid_q, tag2_valid_q;
    logic [ID_W-1:0]       tag1_id_q, tag2_id_q;
    logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q [NUM_REQ];
    logic [DATA_WIDTH-1:0] rsp_data_d [NUM_REQ];

    logic                  p1_used, p2_used;
    logic [ID_W-1:0]       p1_id, p2_id;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slices
        assign addr_arr[g] = req_addr[g*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        assign rsp_data[g*DATA_WIDTH +: DATA_WIDTH] = rsp_data_q[g];
    end

    // Circular scan from ptr: first requester takes port 1, the next one port 2.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        p1_used = 1'b0;
        p1_id   = '0;
        p2_used = 1'b0;
        p2_id   = '0;
        if (!rst) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (req[idx_at(ptr_q, k)]) begin
                    if (!p1_used) begin
                        p1_used = 1'b1;
                        p1_id   = idx_at(ptr_q, k);
                    end else if (!p2_used) begin
                        p2_used = 1'b1;
                        p2_id   = idx_at(ptr_q, k);
                    end
                end
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (p1_used) gnt[p1_id] = 1'b1;
        if (p2_used) gnt[p2_id] = 1'b1;
        rom_addr1 = p1_used ? addr_arr[p1_id] : '0;
        rom_addr2 = p2_used ? addr_arr[p2_id] : '0;
        if (p2_used)      ptr_d = next_id(p2_id);
        else if (p1_used) ptr_d = next_id(p1_id);
        else              ptr_d = ptr_q;
    end

    // Tags name the owner of each ROM port's data, which arrives one cycle after the grant.
    always_comb begin
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        if (tag1_valid_q) begin
            rsp_valid_d[tag1_id_q] = 1'b1;
            rsp_data_d[tag1_id_q]  = rom_dout1;
        end
        if (tag2_valid_q) begin
            rsp_valid_d[tag2_id_q] = 1'b1;
            rsp_data_d[tag2_id_q]  = rom_dout2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q        <= '0;
            tag1_valid_q <= 1'b0;
            tag2_valid_q <= 1'b0;
            tag1_id_q    <= '0;
            tag2_id_q    <= '0;
            rsp_valid_q  <= '0;
            // NOTE: this small response array is visible at the ports, so it is cleared on reset like any register.
            rsp_data_q   <= '{default: '0};
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            ptr_q        <= ptr_d;
            tag1_valid_q <= p1_used;
            tag2_valid_q <= p2_used;
            tag1_id_q    <= p1_id;
            tag2_id_q    <= p2_id;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign rsp_valid = rsp_valid_q;

endmodule

// File: tb/tb_sine_rom_arbiter.sv
// Self-checking bench for sine_rom_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural scoreboard; the ROM holds rom[a] = a ^ 8'hA5.
module tb_sine_rom_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int N  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req;
    logic [N*AW-1:0]   req_addr;
    logic [N-1:0]      gnt;
    logic [N-1:0]      rsp_valid;
    logic [N*DW-1:0]   rsp_data;
    logic [AW-1:0]     rom_addr1, rom_addr2;
    logic [DW-1:0]     rom_dout1, rom_dout2;

    int errors = 0;
    int checks = 0;

    sine_rom_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_addr  (req_addr),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rom_addr1 (rom_addr1),
        .rom_addr2 (rom_addr2),
        .rom_dout1 (rom_dout1),
        .rom_dout2 (rom_dout2)
    );

    always #5 clk = ~clk;

    // Dual-port synchronous ROM with the test image.
    always @(posedge clk) begin
        rom_dout1 <= rom_addr1 ^ 8'hA5;
        rom_dout2 <= rom_addr2 ^ 8'hA5;
    end

    // Behavioural model: round-robin pointer as an int, responses as a due-cycle queue.
    typedef struct {
        int          due;
        int          id;
        logic [7:0]  data;
    } pend_t;

    pend_t       pq[$];
    int          cyc = 0;
    int          m_ptr = 0;
    logic [7:0]  m_data [N];
    int          e_w1, e_w2;
    logic [N-1:0]    e_gnt, e_valid;
    logic [AW-1:0]   e_a1, e_a2;
    logic [N*DW-1:0] e_data;

    function automatic logic [AW-1:0] addr_of(input int i);
        return req_addr[i*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] data_of(input int i);
        return rsp_data[i*DW +: DW];
    endfunction

    // Called once per cycle after inputs are driven: builds the expected outputs.
    task automatic settle();
        pend_t keep[$];
        #1;
        e_w1 = -1;
        e_w2 = -1;
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (req[i]) begin
                    if (e_w1 < 0)      e_w1 = i;
                    else if (e_w2 < 0) e_w2 = i;
                end
            end
        end
        e_gnt = '0;
        if (e_w1 >= 0) e_gnt[e_w1] = 1'b1;
        if (e_w2 >= 0) e_gnt[e_w2] = 1'b1;
        e_a1 = (e_w1 >= 0) ? addr_of(e_w1) : '0;
        e_a2 = (e_w2 >= 0) ? addr_of(e_w2) : '0;
        e_valid = '0;
        foreach (pq[j]) begin
            if (pq[j].due == cyc) begin
                e_valid[pq[j].id] = 1'b1;
                m_data[pq[j].id]  = pq[j].data;
            end else begin
                keep.push_back(pq[j]);
            end
        end
        pq = keep;
        for (int i = 0; i < N; i++) e_data[i*DW +: DW] = m_data[i];
    endtask

    // Applies the clock edge to the model and moves to the next drive point.
    task automatic advance();
        if (rst) begin
            pq.delete();
            for (int i = 0; i < N; i++) m_data[i] = '0;
            m_ptr = 0;
        end else begin
            if (e_w1 >= 0) pq.push_back('{cyc + 2, e_w1, e_a1 ^ 8'hA5});
            if (e_w2 >= 0) pq.push_back('{cyc + 2, e_w2, e_a2 ^ 8'hA5});
            if (e_w2 >= 0)      m_ptr = (e_w2 + 1) % N;
            else if (e_w1 >= 0) m_ptr = (e_w1 + 1) % N;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        req = '0;
        repeat (n) begin
            settle();
            advance();
        end
    endtask

    task automatic reset_cycle();
        rst = 1'b1;
        req = '0;
        settle();
        advance();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b1111;
        for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = 8'h20 + 8'(i);
        for (int k = 0; k < 3; k++) begin
            settle();
            checks++;
            if (gnt !== 4'b0000) begin
                errors++;
                $display("FAIL reset_gnt k=%0d got=%b exp=0000", k, gnt);
            end
            if (k > 0) begin
                checks++;
                if (rsp_valid !== 4'b0000 || rsp_data !== '0) begin
                    errors++;
                    $display("FAIL reset_rsp k=%0d valid=%b data=%h exp 0/0", k, rsp_valid, rsp_data);
                end
            end
            advance();
        end
        rst = 1'b0;
        settle();
        checks++;
        if (gnt !== 4'b0011 || rom_addr1 !== 8'h20 || rom_addr2 !== 8'h21) begin
            errors++;
            $display("FAIL reset_release got gnt=%b a1=%h a2=%h exp 0011/20/21", gnt, rom_addr1, rom_addr2);
        end
        advance();
        req = '0;
        settle();
        advance();
        settle();
        checks++;
        if (rsp_valid !== 4'b0011 || data_of(0) !== 8'h85 || data_of(1) !== 8'h84) begin
            errors++;
            $display("FAIL reset_first_rsp got valid=%b d0=%h d1=%h exp 0011/85/84",
                     rsp_valid, data_of(0), data_of(1));
        end
        advance();
        idle(2);
    endtask

    task automatic test_single();
        logic [7:0] addrs [3];
        logic [7:0] exp_d [3];
        addrs = '{8'h10, 8'h11, 8'h12};
        exp_d = '{8'hB5, 8'hB4, 8'hB7};
        for (int k = 0; k < 6; k++) begin
            if (k < 3) begin
                req = 4'b0100;
                req_addr[2*AW +: AW] = addrs[k];
            end else begin
                req = '0;
            end
            settle();
            if (k < 3) begin
                checks++;
                if (gnt !== 4'b0100 || rom_addr1 !== addrs[k] || rom_addr2 !== 8'h00) begin
                    errors++;
                    $display("FAIL single_gnt k=%0d got gnt=%b a1=%h a2=%h exp 0100/%h/00",
                             k, gnt, rom_addr1, rom_addr2, addrs[k]);
                end
            end
            if (k >= 2 && k <= 4) begin
                checks++;
                if (rsp_valid !== 4'b0100 || data_of(2) !== exp_d[k-2]) begin
                    errors++;
                    $display("FAIL single_rsp k=%0d got valid=%b d2=%h exp 0100/%h",
                             k, rsp_valid, data_of(2), exp_d[k-2]);
                end
            end
            if (k == 5) begin
                checks++;
                if (rsp_valid !== 4'b0000) begin
                    errors++;
                    $display("FAIL single_tail got valid=%b exp 0000", rsp_valid);
                end
            end
            advance();
        end
        idle(1);
    endtask

    task automatic test_contention();
        logic [3:0] pat;
        reset_cycle();
        req = 4'b1111;
        for (int k = 0; k < 10; k++) begin
            settle();
            pat = (k % 2 == 0) ? 4'b0011 : 4'b1100;
            checks++;
            if (gnt !== pat || gnt !== e_gnt || rom_addr1 !== e_a1 || rom_addr2 !== e_a2) begin
                errors++;
                $display("FAIL contention_gnt k=%0d got gnt=%b a1=%h a2=%h exp %b/%h/%h",
                         k, gnt, rom_addr1, rom_addr2, pat, e_a1, e_a2);
            end
            if (k >= 2) begin
                checks++;
                if (rsp_valid !== pat || rsp_data !== e_data) begin
                    errors++;
                    $display("FAIL contention_rsp k=%0d got valid=%b data=%h exp %b/%h",
                             k, rsp_valid, rsp_data, pat, e_data);
                end
            end
            advance();
            for (int i = 0; i < N; i++)
                if (e_gnt[i]) req_addr[i*AW +: AW] = 8'($urandom);
        end
        idle(3);
    endtask

    task automatic test_wrap();
        reset_cycle();
        for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = 8'h40 + 8'(i);
        req = 4'b0011;
        settle();
        checks++;
        if (gnt !== 4'b0011) begin
            errors++;
            $display("FAIL wrap_setup got gnt=%b exp 0011", gnt);
        end
        advance();
        req = 4'b1001;
        settle();
        checks++;
        if (gnt !== 4'b1001 || rom_addr1 !== 8'h43 || rom_addr2 !== 8'h40) begin
            errors++;
            $display("FAIL wrap_grant got gnt=%b a1=%h a2=%h exp 1001/43/40", gnt, rom_addr1, rom_addr2);
        end
        advance();
        req = 4'b0101;
        settle();
        checks++;
        if (rom_addr1 !== 8'h42 || rom_addr2 !== 8'h40) begin
            errors++;
            $display("FAIL wrap_ptr got a1=%h a2=%h exp 42/40", rom_addr1, rom_addr2);
        end
        advance();
        idle(3);
    endtask

    task automatic test_same_addr();
        req = 4'b0011;
        req_addr[0 +: AW]  = 8'hFF;
        req_addr[AW +: AW] = 8'hFF;
        settle();
        checks++;
        if (gnt !== 4'b0011) begin
            errors++;
            $display("FAIL same_gnt got gnt=%b exp 0011", gnt);
        end
        advance();
        req = '0;
        settle();
        advance();
        settle();
        checks++;
        if (rsp_valid !== 4'b0011 || data_of(0) !== 8'h5A || data_of(1) !== 8'h5A) begin
            errors++;
            $display("FAIL same_rsp got valid=%b d0=%h d1=%h exp 0011/5A/5A",
                     rsp_valid, data_of(0), data_of(1));
        end
        advance();
        idle(1);
    endtask

    task automatic test_reset_mid();
        req = 4'b0010;
        req_addr[AW +: AW] = 8'h33;
        settle();
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL mid_gnt got gnt=%b exp 0010", gnt);
        end
        advance();
        rst = 1'b1;
        req = 4'b0010;
        settle();
        checks++;
        if (gnt !== 4'b0000) begin
            errors++;
            $display("FAIL mid_rst_gnt got gnt=%b exp 0000", gnt);
        end
        advance();
        rst = 1'b0;
        req = '0;
        settle();
        checks++;
        if (rsp_valid[1] !== 1'b0 || data_of(1) !== 8'h00) begin
            errors++;
            $display("FAIL mid_rsp got valid1=%b d1=%h exp 0/00", rsp_valid[1], data_of(1));
        end
        advance();
        idle(2);
    endtask

    task automatic test_random();
        logic [N-1:0] last_gnt;
        last_gnt = '0;
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 49) == 0);
            for (int i = 0; i < N; i++) begin
                if (!req[i] || last_gnt[i]) begin
                    req[i] = 1'($urandom_range(0, 1));
                    req_addr[i*AW +: AW] = 8'($urandom);
                end
            end
            settle();
            checks++;
            if (gnt !== e_gnt || rom_addr1 !== e_a1 || rom_addr2 !== e_a2) begin
                errors++;
                $display("FAIL rand_gnt c=%0d got gnt=%b a1=%h a2=%h exp %b/%h/%h",
                         c, gnt, rom_addr1, rom_addr2, e_gnt, e_a1, e_a2);
            end
            checks++;
            if (rsp_valid !== e_valid || rsp_data !== e_data) begin
                errors++;
                $display("FAIL rand_rsp c=%0d got valid=%b data=%h exp %b/%h",
                         c, rsp_valid, rsp_data, e_valid, e_data);
            end
            last_gnt = e_gnt;
            advance();
        end
        rst = 1'b0;
        idle(3);
    endtask

    initial begin
        req      = '0;
        req_addr = '0;
        rst      = 1'b1;
        for (int i = 0; i < N; i++) m_data[i] = '0;
        test_reset();
        test_single();
        test_contention();
        test_wrap();
        test_same_addr();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sine_rom_arbiter.md
Name: sine_rom_arbiter

Overview:
- Round-robin arbiter that shares the dual-port synchronous sine ROM between NUM_REQ independent requesters (e.g. several signal-generator channels).
- Grants up to two requests per cycle, one per ROM port, and drives the ROM addr1/addr2 inputs.
- Tracks in-flight reads through the ROM's 1-cycle latency and routes dout1/dout2 back to the owning requester with a registered response.
- Sits between the per-channel phase accumulators and the ROM instance.

Parameters:
- ADDRESS_WIDTH, 8, ROM address width (matches ROM).
- DATA_WIDTH, 8, ROM data width (matches ROM).
- NUM_REQ, 4, number of requesters; legal range 2..8.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester read request; held with its address until granted.
- req_addr  in  NUM_REQ*ADDRESS_WIDTH  packed addresses; slice i = requester i.
- gnt  out  NUM_REQ  combinational grant; a transfer occurs on any cycle with req[i]&gnt[i].
- rsp_valid  out  NUM_REQ  registered 1-cycle pulse: rsp_data slice i is valid.
- rsp_data  out  NUM_REQ*DATA_WIDTH  packed registered read data; slice i holds its last value between pulses.
- rom_addr1  out  ADDRESS_WIDTH  to ROM addr1.
- rom_addr2  out  ADDRESS_WIDTH  to ROM addr2.
- rom_dout1  in  DATA_WIDTH  from ROM dout1.
- rom_dout2  in  DATA_WIDTH  from ROM dout2.

Behaviour:
- State: round-robin pointer ptr (clog2(NUM_REQ) bits); two in-flight tags (valid bit plus requester id), one per port.
- Reset (rst=1 at an edge): ptr=0, both tag valids=0, rsp_valid=0, rsp_data=0. While rst=1, gnt=0 regardless of req.
- Arbitration (combinational, every cycle rst=0):
  - Port 1 goes to the first i with req[i]=1, scanning ptr, ptr+1, ... with wrap mod NUM_REQ.
  - Port 2 goes to the next requesting index after the port-1 winner, same circular scan, stopping before returning to ptr.
  - A requester never receives both ports in one cycle; at most two gnt bits are set.
  - With zero requests, gnt=0. With one request, only port 1 is used.
- ROM addresses: rom_addr1/2 = req_addr of the port winner; 0 when the port is unused.
- Pointer update at the edge: ptr <= (last granted index + 1) mod NUM_REQ, where last granted = port-2 winner if any, else port-1 winner. No grant: ptr unchanged.
- Tag stage: at the end of grant cycle N, tagK_valid <= port K used, tagK_id <= winner.
- Response stage: at the end of cycle N+1 (ROM dout valid):
  - For each valid tag: rsp_data[id] <= matching rom_doutK, rsp_valid[id] <= 1.
  - All other rsp_valid bits <= 0.
- Latency: gnt in cycle N, rsp_valid/rsp_data visible in cycle N+2.
- Throughput: fully pipelined. Back-to-back grants to the same requester give back-to-back rsp_valid pulses.
- The two tags never share an id, so there are no write conflicts on rsp_data.
- Reset mid-operation: all in-flight tags are dropped. No rsp_valid for grants made in the cycle before, or the cycle of, rst. rsp_data is cleared.
- Requesters may change req_addr freely while req=0. While req=1 and gnt=0, address must be held; a change is not an error but is sampled only on the grant cycle.

Test Plan:
- Bench setup: ROM instance loaded with test image rom[a] = a ^ 8'hA5. Unless stated otherwise, defaults apply.
- Reset: hold rst 3 cycles with req=4'b1111 -> gnt=0, rsp_valid=0, rsp_data all 0. First cycle after release: gnt=4'b0011, rom_addr1=addr0, rom_addr2=addr1.
- Single requester: req=4'b0100, addresses 8'h10, 8'h11, 8'h12 on consecutive cycles -> gnt[2]=1 every cycle, rom_addr2=0. rsp_valid[2] pulses in cycles 2..4 with data 8'hB5, 8'hB4, 8'hB7.
- Full contention: req=4'b1111 held -> gnt alternates 0011, 1100, 0011, ... and each requester gets exactly one response every 2 cycles.
- Wrap-around: drive ptr to 2 (one cycle with req=4'b0011 granted), then req=4'b1001 -> port1 = requester 3, port2 = requester 0, then ptr=1.
- Same address, both ports: req=4'b0011, both addresses 8'hFF -> rsp_valid=4'b0011 in cycle N+2, both data = 8'h5A.
- Reset mid-flight: grant requester 1 in cycle N, assert rst in cycle N+1 -> rsp_valid[1] stays 0 in cycle N+2, rsp_data[1]=0.
